// File: rtl/alu_ctrl_md_if.sv
// rtl/alu_ctrl_md_if.sv - decode/multiply bus between the pipeline and alu_ctrl_md
interface alu_ctrl_md_if #(
  parameter int WIDTH = 32
);
  logic             valid;
  logic [1:0]       aluOP;
  logic [5:0]       funct;
  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;
  logic [3:0]       aluSel;
  logic             stall;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             mdDone;

  modport master (
    output valid, aluOP, funct, opA, opB,
    input  aluSel, stall, hi, lo, mdDone
  );

  modport slave (
    input  valid, aluOP, funct, opA, opB,
    output aluSel, stall, hi, lo, mdDone
  );
endinterface

// File: rtl/alu_ctrl_md.sv
// rtl/alu_ctrl_md.sv - ALU control decode plus iterative shift-add mult/multu unit
module alu_ctrl_md #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_ctrl_md_if.slave bus
);
  localparam int             CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);
  localparam logic [0:0]     IDLE = 1'b0;
  localparam logic [0:0]     MULT = 1'b1;

  logic [0:0]         state;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;
  logic               sign_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               done_q;

  logic               is_mult;
  logic               is_signed;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] acc_next;
  logic [2*WIDTH-1:0] prod;
  logic [3:0]         sel;

  assign is_mult   = bus.valid && (bus.aluOP == 2'b10) && (bus.funct[5:1] == 5'b01100);
  assign is_signed = ~bus.funct[0];

  // Negating -2^(WIDTH-1) leaves the same bit pattern, which is the correct unsigned magnitude.
  assign abs_a = (is_signed && bus.opA[WIDTH-1]) ? -bus.opA : bus.opA;
  assign abs_b = (is_signed && bus.opB[WIDTH-1]) ? -bus.opB : bus.opB;

  assign sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (mplier[0] ? mcand : {WIDTH{1'b0}})};
  assign acc_next = {sum, acc[WIDTH-1:1]};
  assign prod     = sign_q ? -acc_next : acc_next;

  always_comb begin
    sel = 4'b0000;
    case (bus.aluOP)
      2'b00: sel = 4'b0000;
      2'b01: sel = 4'b0001;
      2'b11: sel = 4'b0011;
      default: begin
        case (bus.funct)
          6'b100000: sel = 4'b0000;
          6'b100010: sel = 4'b0001;
          6'b100100: sel = 4'b0010;
          6'b100101: sel = 4'b0011;
          6'b101010: sel = 4'b0100;
          6'b100111: sel = 4'b0101;
          6'b000000: sel = 4'b0110;
          6'b000010: sel = 4'b0111;
          6'b010000: sel = 4'b1000;
          6'b010010: sel = 4'b1001;
          default:   sel = 4'b0000;
        endcase
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      sign_q <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state == IDLE) begin
        if (is_mult) begin
          mcand  <= abs_a;
          mplier <= abs_b;
          sign_q <= is_signed & (bus.opA[WIDTH-1] ^ bus.opB[WIDTH-1]);
          acc    <= '0;
          cnt    <= '0;
          state  <= MULT;
        end
      end else begin
        acc    <= acc_next;
        mplier <= mplier >> 1;
        cnt    <= cnt + 1'b1;
        if (cnt == LAST) begin
          hi_q   <= prod[2*WIDTH-1:WIDTH];
          lo_q   <= prod[WIDTH-1:0];
          done_q <= 1'b1;
          state  <= IDLE;
        end
      end
    end
  end

  // The retiring cycle drops stall so the pipeline can advance past the mult.
  assign bus.stall  = (state == IDLE) ? is_mult : (cnt != LAST);
  assign bus.aluSel = sel;
  assign bus.hi     = hi_q;
  assign bus.lo     = lo_q;
  assign bus.mdDone = done_q;
endmodule
